// File: rtl/stage_sequencer.sv
// stage_sequencer: multicycle stage controller for the fetch/decode/execute/data/writeback datapath.
// Latency: 5 cycles per zero-wait instruction; every memory ready-low cycle adds one.
// Backpressure: holds FETCH/DATA while imem/dmem ready is low; faults after TIMEOUT_CYCLES waits.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_run, i_step           continuous run level / single-instruction step pulse
//   i_halt_instr            decoder halt flag, sampled in DECODE
//   i_dmem_access           decoder load/store flag, sampled in EXEC
//   i_imem_ready            instruction memory data valid
//   i_dmem_ready            data memory access complete
//   o_stage                 one-hot stage {wb, data, exec, decode, fetch}; 0 when not executing
//   o_imem_req, o_dmem_req  memory requests
//   o_retire                writeback cycle strobe
//   o_busy                  high in FETCH..WB
//   o_halted, o_fault       sticky halt / timeout status, cleared only by reset
//   o_cycle_count, o_retired_count  performance counters (only with PERF_COUNTERS_EN)
//
// Build option: define PERF_COUNTERS_EN to add the performance counter outputs.

module stage_sequencer #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_run,
  input  logic       i_step,
  input  logic       i_halt_instr,
  input  logic       i_dmem_access,
  input  logic       i_imem_ready,
  input  logic       i_dmem_ready,
  output logic [4:0] o_stage,
  output logic       o_imem_req,
  output logic       o_dmem_req,
  output logic       o_retire,
  output logic       o_busy,
  output logic       o_halted,
  output logic       o_fault
`ifdef PERF_COUNTERS_EN
  ,
  output logic [COUNT_WIDTH-1:0] o_cycle_count,
  output logic [COUNT_WIDTH-1:0] o_retired_count
`endif
);

  // Wait counter only needs to reach TIMEOUT_CYCLES.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW:0] TIMEOUT_LIM = (CW+1)'(TIMEOUT_CYCLES);

  typedef enum logic [7:0] {
    ST_IDLE   = 8'b0000_0001,
    ST_FETCH  = 8'b0000_0010,
    ST_DECODE = 8'b0000_0100,
    ST_EXEC   = 8'b0000_1000,
    ST_DATA   = 8'b0001_0000,
    ST_WB     = 8'b0010_0000,
    ST_HALT   = 8'b0100_0000,
    ST_FAULT  = 8'b1000_0000
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_step_mode;
  logic          w_step_mode_nxt;
  logic          r_access;
  logic          w_access_nxt;
  logic [CW-1:0] r_wait_cnt;
  logic [CW-1:0] w_wait_cnt_nxt;
  logic [CW:0]   w_wait_cnt_inc;
  logic [CW-1:0] w_wait_cnt_sat;
  logic          w_timeout;

  assign w_wait_cnt_inc = {1'b0, r_wait_cnt} + 1'b1;
  // Saturate rather than wrap; only reachable when the timeout is disabled.
  assign w_wait_cnt_sat = (r_wait_cnt == '1) ? r_wait_cnt : w_wait_cnt_inc[CW-1:0];
  // This ready-low cycle would be wait number TIMEOUT_CYCLES: give up.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_wait_cnt_inc == TIMEOUT_LIM);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_step_mode <= 1'b0;
      r_access    <= 1'b0;
      r_wait_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_step_mode <= w_step_mode_nxt;
      r_access    <= w_access_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_step_mode_nxt = r_step_mode;
    w_access_nxt    = r_access;
    // Counter clears whenever a wait ends or is not in progress.
    w_wait_cnt_nxt  = '0;
    case (r_state)
      ST_IDLE: begin
        if (i_run) begin
          w_state_nxt     = ST_FETCH;
          w_step_mode_nxt = 1'b0;
        end else if (i_step) begin
          w_state_nxt     = ST_FETCH;
          w_step_mode_nxt = 1'b1;
        end
      end
      ST_FETCH: begin
        // Ready beats timeout, so ready in the last allowed cycle is taken.
        if (i_imem_ready) begin
          w_state_nxt = ST_DECODE;
        end else if (w_timeout) begin
          w_state_nxt = ST_FAULT;
        end else begin
          w_wait_cnt_nxt = w_wait_cnt_sat;
        end
      end
      ST_DECODE: begin
        w_state_nxt = i_halt_instr ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        w_access_nxt = i_dmem_access;
        w_state_nxt  = ST_DATA;
      end
      ST_DATA: begin
        if (!r_access || i_dmem_ready) begin
          w_state_nxt  = ST_WB;
          w_access_nxt = 1'b0;
        end else if (w_timeout) begin
          w_state_nxt = ST_FAULT;
        end else begin
          w_wait_cnt_nxt = w_wait_cnt_sat;
        end
      end
      ST_WB: begin
        if (i_run && !r_step_mode) begin
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt     = ST_IDLE;
          w_step_mode_nxt = 1'b0;
        end
      end
      ST_HALT:  w_state_nxt = ST_HALT;
      ST_FAULT: w_state_nxt = ST_FAULT;
      default: begin
        // Illegal encoding: park safely.
        w_state_nxt     = ST_IDLE;
        w_step_mode_nxt = 1'b0;
        w_access_nxt    = 1'b0;
      end
    endcase
  end

  // Moore outputs, decoded from registered state only.
  assign o_stage    = {r_state == ST_WB, r_state == ST_DATA, r_state == ST_EXEC,
                       r_state == ST_DECODE, r_state == ST_FETCH};
  assign o_imem_req = (r_state == ST_FETCH);
  assign o_dmem_req = (r_state == ST_DATA) && r_access;
  assign o_retire   = (r_state == ST_WB);
  assign o_busy     = |o_stage;
  assign o_halted   = (r_state == ST_HALT);
  assign o_fault    = (r_state == ST_FAULT);

`ifdef PERF_COUNTERS_EN
  logic [COUNT_WIDTH-1:0] r_cycle_count;
  logic [COUNT_WIDTH-1:0] r_retired_count;

  // Both counters wrap naturally modulo 2^COUNT_WIDTH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cycle_count   <= '0;
      r_retired_count <= '0;
    end else begin
      if (o_busy)   r_cycle_count   <= r_cycle_count + 1'b1;
      if (o_retire) r_retired_count <= r_retired_count + 1'b1;
    end
  end

  assign o_cycle_count   = r_cycle_count;
  assign o_retired_count = r_retired_count;
`else
  // COUNT_WIDTH only shapes the counter outputs, which are absent in this build.
  if (COUNT_WIDTH < 1) begin : g_count_width_unused
  end
`endif

endmodule
